// File: rtl/e_mdu_pkg.sv
// Shared E-stage decode constants: forwarding selects and multiply/divide op codes.
// Helpers classify MDU ops so every user agrees on which ops occupy the unit.
package e_mdu_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EM  = 2'd1;
  localparam logic [1:0] FWD_MW  = 2'd2;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 32x32 multiply / divide producing a {hi, lo} result pair.
// Signed divide works on magnitudes so INT_MIN / -1 naturally yields 0x80000000 rem 0.
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] quo;
  logic [31:0] rem;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // One shared divider; a zero divisor is replaced so the result is defined (the caller discards it).
  assign div_a = (op == MDU_DIV) ? abs_a : a;
  assign div_b = (b == 32'd0) ? 32'd1 : ((op == MDU_DIV) ? abs_b : b);
  assign quo   = div_a / div_b;
  assign rem   = div_a % div_b;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        res_lo = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
        res_hi = a[31] ? (~rem + 32'd1) : rem;
      end
      MDU_DIVU: begin
        res_lo = quo;
        res_hi = rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, latches the result at start, commits it after a
// fixed busy count. Ops arriving while the counter runs are ignored (hazard unit prevents them).
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          start;
  logic          div_zero;

  mdu_calc u_calc (
    .op     (mdu_op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign start    = is_muldiv(mdu_op) && (cnt == '0);
  assign div_zero = is_div(mdu_op) && (rt_val == 32'd0);
  assign busy     = start || (cnt != '0);

  always_comb begin
    mf_out = 32'd0;
    if (mdu_op == MDU_MFHI)      mf_out = hi;
    else if (mdu_op == MDU_MFLO) mf_out = lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (start) begin
      cnt <= is_div(mdu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      // Divide by zero still occupies the unit but commits the unchanged HI/LO.
      pend_hi <= div_zero ? hi : res_hi;
      pend_lo <= div_zero ? lo : res_lo;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (mdu_op == MDU_MTHI) begin
      hi <= rs_val;
    end else if (mdu_op == MDU_MTLO) begin
      lo <= rs_val;
    end
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit. Consumes the forwarded operands and decoded op of the instruction held in the D/E pipeline register, models multi-cycle multiply/divide latency with a busy counter, and owns the architectural HI/LO registers. Its `busy` output feeds the hazard unit, which stalls any multiply/divide-class instruction in D while the unit is occupied. MFHI/MFLO results leave through `mf_out` into the E-stage result mux and then to E/M.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles after MULT/MULTU start
- `DIV_CYCLES`, 10, busy cycles after DIV/DIVU start

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset; clock `clk`
- `mdu_op`  in  4  decoded op of E-stage instr; 0 for bubbles and flushed slots
- `rs_val`  in  32  forwarded rs operand (dividend / multiplicand / MT source)
- `rt_val`  in  32  forwarded rt operand (divisor / multiplier)
- `busy`  out  1  high during the start cycle and while the counter is non-zero
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO
- `mf_out`  out  32  `hi` for MFHI, `lo` for MFLO, else 0

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; 9–15 are treated as NONE.
- `start` (internal) = op in {MULT, MULTU, DIV, DIVU} and `cnt`==0.
- On `start`: compute the 64-bit result combinationally and latch it into `pend_hi`/`pend_lo`. Load `cnt` with MULT_CYCLES or DIV_CYCLES.
- MULT: {HI,LO} = signed rs × signed rt. MULTU: unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divisor 0, DIV or DIVU: busy still runs DIV_CYCLES; HI and LO keep their prior values (`pend_*` loaded from current `hi`/`lo`).
- Counter: each edge with `cnt`!=0 decrements it. On the edge where `cnt`==1, `hi`<=`pend_hi` and `lo`<=`pend_lo`.
- MTHI/MTLO with `cnt`==0: `hi`/`lo` <= `rs_val` at the next edge.
- Any op other than NONE arriving while `cnt`!=0 is ignored: no start, no MT write, and `mf_out` still reflects the current register. The hazard unit guarantees this never occurs. The bench checks that it is harmless.
- `mf_out` is combinational from the current `hi`/`lo` and is never the pending value.

## Timing
- Reset: `hi`=0, `lo`=0, `cnt`=0, `pend_hi`=`pend_lo`=0; `busy`=0 once `mdu_op` is NONE.
- Start sampled at edge t: `busy` is high combinationally in the cycle before t. It stays high for cycles t..t+N-1, where N is MULT_CYCLES or DIV_CYCLES. HI/LO update at edge t+N, and `busy` is low in the cycle after that edge.
- A new multiply/divide may start in the same cycle `busy` falls, and is sampled at edge t+N+1 at the earliest.
- Reset mid-operation: `cnt` clears and the pending result is discarded. HI/LO become 0, not the pending value.
- MT followed by MF in the next cycle: MF sees the new value.

## Structure
- Shared header holds the op-code defines `MDU_NONE`…`MDU_MTLO` alongside the existing forwarding-select defines.
- One combinational sub-module, `mdu_calc`, takes `op`, `a`, `b` and produces `res_hi` and `res_lo`. It implements the signed/unsigned arithmetic and the divide-by-zero/overflow rules.
- The counter, HI/LO and pending registers live in `e_mdu`.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3, start at edge 0 -> `busy` high for cycles 0..4; after edge 5, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles, HI=0xFFFFFFFE and LO=0x00000001.
- DIV rs=−7 (0xFFFFFFF9), rt=2 -> after 10 cycles, LO=0xFFFFFFFD (−3) and HI=0xFFFFFFFF (−1). MFLO the next cycle gives `mf_out`=0xFFFFFFFD.
- MTHI 0x12345678, then DIVU rs=5, rt=0 -> `busy` high for 10 cycles; HI stays 0x12345678 and LO stays at its prior value.
- DIV started, then `reset` asserted at cycle 4 -> after the reset edge, `hi`=`lo`=0 and `busy`=0. No late HI/LO update occurs at cycle 10.
- MTLO 0xAAAA issued while `cnt`=3 -> ignored; LO equals the multiply/divide result afterwards.
